// File: rtl/chip8_mem_responder.sv
// chip8_mem_responder: memory-side responder for the CHIP-8 core bus.
// Serves byte reads, byte writes and two-byte big-endian instruction fetches
// from an internal 2**ADDR_W x DATA_W array. After every reset the whole array
// is overwritten with CLEAR_VAL before any request is accepted.
//
// Optional feature macro: MEM_WRPROT_EN
//   defined   - writes to addr < WP_LIMIT are dropped; ack and wp_err pulse together
//   undefined - every address is writable, wp_err is constant 0
//
// Ports:
//   clk         system clock, all logic on posedge
//   rst         synchronous reset, active-high
//   req         request strobe, sampled only while busy=0
//   memwrite    1 = byte write, 0 = read (sampled with req)
//   fetch16     1 = two-byte fetch, ignored for writes (sampled with req)
//   addr        byte address
//   write_data  write byte
//   read_data   registered read byte (high byte on fetch)
//   read_word   registered {mem[a], mem[a+1]} on fetch
//   ack         one-cycle completion pulse
//   busy        high while clearing or mid-fetch
//   wp_err      one-cycle pulse on a dropped protected write
module chip8_mem_responder #(
  parameter int unsigned       ADDR_W    = 8,
  parameter int unsigned       DATA_W    = 8,
  parameter logic [DATA_W-1:0] CLEAR_VAL = 8'h00,
  parameter logic [ADDR_W-1:0] WP_LIMIT  = 8'h50
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  memwrite,
  input  logic                  fetch16,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     write_data,
  output logic [DATA_W-1:0]     read_data,
  output logic [2*DATA_W-1:0]   read_word,
  output logic                  ack,
  output logic                  busy,
  output logic                  wp_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] CNT_MAX = {ADDR_W{1'b1}};

  localparam logic [1:0] CLEAR    = 2'd0;
  localparam logic [1:0] IDLE     = 2'd1;
  localparam logic [1:0] FETCH_LO = 2'd2;

`ifdef MEM_WRPROT_EN
  localparam logic WP_EN = 1'b1;
`else
  localparam logic WP_EN = 1'b0;
`endif

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]          state, state_nxt;
  logic [ADDR_W-1:0]   clear_cnt, clear_cnt_nxt;
  logic [ADDR_W-1:0]   fetch_addr, fetch_addr_nxt;
  logic                busy_nxt, ack_nxt, wp_err_nxt;
  logic [DATA_W-1:0]   read_data_nxt;
  logic [2*DATA_W-1:0] read_word_nxt;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                wr_blocked;

  // Protected write: the font area is read-only to the bus, never to the clear.
  assign wr_blocked = WP_EN & (addr < WP_LIMIT);

  // Next-state, array write port and output next values.
  always_comb begin
    state_nxt      = state;
    clear_cnt_nxt  = clear_cnt;
    fetch_addr_nxt = fetch_addr;
    busy_nxt       = busy;
    ack_nxt        = 1'b0;
    wp_err_nxt     = 1'b0;
    read_data_nxt  = read_data;
    read_word_nxt  = read_word;
    mem_we         = 1'b0;
    mem_waddr      = addr;
    mem_wdata      = write_data;

    case (state)
      CLEAR: begin
        mem_we        = 1'b1;
        mem_waddr     = clear_cnt;
        mem_wdata     = CLEAR_VAL;
        clear_cnt_nxt = clear_cnt + ADDR_W'(1);
        if (clear_cnt == CNT_MAX) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end
      end
      IDLE: begin
        if (req) begin
          if (memwrite) begin
            ack_nxt = 1'b1;
            if (wr_blocked) wp_err_nxt = 1'b1;
            else            mem_we     = 1'b1;
          end else if (fetch16) begin
            read_data_nxt                      = mem[addr];
            read_word_nxt[2*DATA_W-1:DATA_W]   = mem[addr];
            fetch_addr_nxt                     = addr + ADDR_W'(1);
            busy_nxt                           = 1'b1;
            state_nxt                          = FETCH_LO;
          end else begin
            read_data_nxt = mem[addr];
            ack_nxt       = 1'b1;
          end
        end
      end
      FETCH_LO: begin
        read_word_nxt[DATA_W-1:0] = mem[fetch_addr];
        ack_nxt                   = 1'b1;
        busy_nxt                  = 1'b0;
        state_nxt                 = IDLE;
      end
      default: begin
        state_nxt     = CLEAR;
        clear_cnt_nxt = '0;
        busy_nxt      = 1'b1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLEAR;
      clear_cnt  <= '0;
      fetch_addr <= '0;
      busy       <= 1'b1;
      ack        <= 1'b0;
      wp_err     <= 1'b0;
      read_data  <= '0;
      read_word  <= '0;
    end else begin
      state      <= state_nxt;
      clear_cnt  <= clear_cnt_nxt;
      fetch_addr <= fetch_addr_nxt;
      busy       <= busy_nxt;
      ack        <= ack_nxt;
      wp_err     <= wp_err_nxt;
      read_data  <= read_data_nxt;
      read_word  <= read_word_nxt;
    end
  end

  // Array write port; suppressed during reset so an aborted write cannot land.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_chip8_mem_responder.sv
// tb_chip8_mem_responder: scoreboard bench for chip8_mem_responder.
// Expected responses (arrival cycle, read_data, read_word, wp_err) are pushed
// when a request is driven and popped when ack is observed.
module tb_chip8_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        memwrite = 1'b0;
  logic        fetch16 = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [7:0]  write_data = 8'h00;
  logic [7:0]  read_data;
  logic [15:0] read_word;
  logic        ack;
  logic        busy;
  logic        wp_err;

  chip8_mem_responder dut (
    .clk(clk), .rst(rst), .req(req), .memwrite(memwrite), .fetch16(fetch16),
    .addr(addr), .write_data(write_data), .read_data(read_data),
    .read_word(read_word), .ack(ack), .busy(busy), .wp_err(wp_err)
  );

  always #5 clk = ~clk;

`ifdef MEM_WRPROT_EN
  localparam bit WP_ON = 1'b1;
`else
  localparam bit WP_ON = 1'b0;
`endif

  typedef struct {
    int          exp_cyc;
    logic [7:0]  rd;
    logic [15:0] rw;
    logic        wp;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mem_m [256];
  logic [7:0]  m_rd;
  logic [15:0] m_rw;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: sample on the falling edge, match each ack against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (ack === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_ack", 32'(ack), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ack_cycle", 32'(cyc), 32'(e.exp_cyc));
        chk("read_data", 32'(read_data), 32'(e.rd));
        chk("read_word", 32'(read_word), 32'(e.rw));
        chk("wp_err", 32'(wp_err), 32'(e.wp));
      end
    end else begin
      if (wp_err === 1'b1) chk("wp_err_no_ack", 32'(wp_err), 32'd0);
      if (sb.size() > 0 && sb[0].exp_cyc < cyc) begin
        chk("ack_missing", 32'(ack), 32'd1);
        void'(sb.pop_front());
      end
    end
  end

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    logic blk;
    blk = WP_ON && (a < 8'h50);
    if (!blk) mem_m[a] = d;
    e.exp_cyc = cyc + 1; e.rd = m_rd; e.rw = m_rw; e.wp = blk;
    sb.push_back(e);
    req = 1'b1; memwrite = 1'b1; fetch16 = 1'b0; addr = a; write_data = d;
    @(negedge clk); #1;
    req = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a);
    exp_t e;
    m_rd = mem_m[a];
    e.exp_cyc = cyc + 1; e.rd = m_rd; e.rw = m_rw; e.wp = 1'b0;
    sb.push_back(e);
    req = 1'b1; memwrite = 1'b0; fetch16 = 1'b0; addr = a;
    @(negedge clk); #1;
    req = 1'b0;
  endtask

  // Issue a fetch; in the FETCH_LO cycle optionally present a request that must be dropped.
  task automatic fetch(input logic [7:0] a, input bit drop);
    exp_t e;
    logic [7:0] a1;
    a1 = a + 8'd1;
    m_rd = mem_m[a];
    m_rw = {mem_m[a], mem_m[a1]};
    e.exp_cyc = cyc + 2; e.rd = m_rd; e.rw = m_rw; e.wp = 1'b0;
    sb.push_back(e);
    req = 1'b1; memwrite = 1'b0; fetch16 = 1'b1; addr = a;
    @(negedge clk); #1;
    chk("busy_in_fetch", 32'(busy), 32'd1);
    if (drop) begin
      req = 1'b1; memwrite = 1'b0; fetch16 = 1'b0; addr = 8'h20;
    end else begin
      req = 1'b0;
    end
    @(negedge clk); #1;
    req = 1'b0; fetch16 = 1'b0;
    chk("busy_after_fetch", 32'(busy), 32'd0);
  endtask

  // Pulse reset for one cycle, check reset values and the 256-cycle clear length.
  task automatic do_reset();
    int cnt;
    rst = 1'b1; req = 1'b0;
    sb.delete();
    @(negedge clk); #1;
    rst = 1'b0;
    chk("rst_read_data", 32'(read_data), 32'd0);
    chk("rst_read_word", 32'(read_word), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_wp_err", 32'(wp_err), 32'd0);
    for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
    m_rd = 8'h00; m_rw = 16'h0000;
    cnt = 0;
    while (busy === 1'b1 && cnt < 400) begin
      cnt++;
      @(negedge clk); #1;
    end
    chk("clear_len", 32'(cnt), 32'd256);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset clear
    do_reset();
    wr(8'h00, 8'h11); wr(8'h7F, 8'h22); wr(8'hFF, 8'h33);
    rd(8'h7F);
    do_reset();
    rd(8'h00); rd(8'h7F); rd(8'hFF);

    // 2: byte write then read-after-write
    wr(8'h10, 8'hA5);
    rd(8'h10);

    // 3: fetch wrapping at the top of the array
    wr(8'hFF, 8'h12); wr(8'h00, 8'h34);
    fetch(8'hFF, 1'b0);
    fetch(8'h10, 1'b0);

    // 4: streaming reads, and a request dropped during a fetch
    for (int i = 0; i < 4; i++) wr(8'(8'h20 + i), 8'(8'hC0 + i));
    for (int i = 0; i < 4; i++) rd(8'(8'h20 + i));
    fetch(8'h21, 1'b1);
    wr(8'h30, 8'h5A); rd(8'h30); fetch(8'h30, 1'b0);

    // 6: write protection boundary
    wr(8'h4F, 8'hEE); wr(8'h50, 8'hEE);
    rd(8'h4F); rd(8'h50);

    // 5: reset in the FETCH_LO cycle aborts without ack
    repeat (2) @(negedge clk);
    #1;
    req = 1'b1; memwrite = 1'b0; fetch16 = 1'b1; addr = 8'h20;
    @(negedge clk); #1;
    req = 1'b0; fetch16 = 1'b0;
    chk("busy_pre_abort", 32'(busy), 32'd1);
    do_reset();
    rd(8'h20); rd(8'h50); fetch(8'hFF, 1'b0);

    repeat (4) @(negedge clk);
    #1;
    if (sb.size() != 0) chk("drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
